conv2_sched: RTL and testbench
==============================

# conv2_sched

Controller that sequences the second convolution stage. On a start pulse it walks every output position and output-channel group. For each step it issues one request to the conv2 MAC core under a valid/ready handshake, carrying the matching slice of the conv2 bias vector. It also tracks how many requests are in flight and reports completion once every result has returned. It sits between the stage-level CNN top controller and the conv2 core, and takes the flat bias bus from the conv2 bias ROM.

## Interface
- CO, 8, conv2 output channels (`ST2_Conv_CO)
- CO_PAR, 2, output channels per core request; CO % CO_PAR == 0
- B_BW, 16, bias word width (`ST2_B_BW)
- OH, 10, output rows
- OW, 10, output columns
- MAX_INFL, 4, maximum requests in flight (≥1)
- NG = CO/CO_PAR (derived); RW/CW/GW = $clog2 of OH/OW/NG, minimum 1
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; honoured only in IDLE
- i_bias  in  CO*B_BW  signed bias bus; channel c at [c*B_BW +: B_BW]
- o_req_valid  out  1  request valid
- i_req_ready  in  1  core accepts request
- o_row  out  RW  output row of request
- o_col  out  CW  output column of request
- o_grp  out  GW  channel group index g (channels g*CO_PAR .. g*CO_PAR+CO_PAR-1)
- o_bias  out  CO_PAR*B_BW  bias slice for group g, lane k = channel g*CO_PAR+k
- o_last  out  1  marks final request of the frame
- i_res_valid  in  1  one-cycle pulse, core finished one request
- o_busy  out  1  high in RUN and DRAIN
- o_done  out  1  one-cycle pulse at frame completion
- o_err  out  1  sticky: result received with nothing in flight; cleared by accepted start

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: i_start clears counters, clears infl, clears o_err, and moves to RUN.
- RUN: o_req_valid = 1 whenever infl < MAX_INFL. A request is accepted when valid & ready.
- Iteration order: grp fastest, then col, then row. The counters are (row, col, grp) and start at (0,0,0).
- On acceptance:
  - grp increments. On wrap to 0, col increments. On col wrap to 0, row increments.
  - Acceptance of the request at (OH-1, OW-1, NG-1) moves to DRAIN.
- o_last = 1 iff the current counters equal (OH-1, OW-1, NG-1).
- o_row, o_col, o_grp, o_last are driven from registered counters. o_bias is combinationally sliced from i_bias by o_grp.
- Payload is stable while o_req_valid is high and ready is low.
- In-flight counter infl (width $clog2(MAX_INFL+1)):
  - +1 on acceptance; -1 on i_res_valid.
  - Both in the same cycle: unchanged.
  - i_res_valid with infl == 0 and no acceptance in that cycle: infl stays 0 and o_err is set. This applies in any state.
- DRAIN: o_req_valid = 0. When infl reaches 0 (including a result arriving in the DRAIN entry cycle), move to DONE.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
- i_start outside IDLE is ignored. A mid-frame restart is not supported.
- Total requests per frame = OH*OW*NG.

## Timing
- Reset values (async on reset_n low): state IDLE; o_req_valid 0; o_row/o_col/o_grp 0; o_last 0; infl 0; o_busy 0; o_done 0; o_err 0.
- Reset asserted mid-frame aborts immediately. No o_done is produced. Late i_res_valid pulses after reset release set o_err.
- i_start at edge t: o_busy = 1 and o_req_valid = 1 from cycle t+1.
- With ready held high and results returning within MAX_INFL cycles, one request is accepted per cycle.
- o_done asserts one cycle after the DRAIN cycle in which infl becomes 0. o_busy is 0 in that o_done cycle.
- o_req_valid deasserts in the same cycle as infl reaches MAX_INFL. There is no combinational path from i_req_ready to o_req_valid.
- A new i_start is accepted in the cycle after o_done (IDLE).

## Test plan
- OH=OW=2, CO=8, CO_PAR=2. Ready held high, i_res_valid one cycle after each acceptance. Required:
  - 16 requests in order (0,0,0),(0,0,1)…(1,1,3).
  - o_last only on the 16th request.
  - o_done 2 cycles after the final result; o_busy drops in that cycle.
- i_bias channel c = 0x0100+c. Required: at grp=2, o_bias = {0x0105,0x0104}, and the payload holds across 3 cycles of ready low.
- MAX_INFL=4 with no results. Required: exactly 4 acceptances, then o_req_valid = 0. One i_res_valid pulse produces exactly one more acceptance.
- i_res_valid coincident with an acceptance at infl=3. Required: infl stays 3 and o_req_valid stays high.
- i_res_valid in IDLE. Required: o_err = 1 and held. The next i_start clears it. i_start during RUN is ignored, so the request count is unchanged.
- Assert reset_n low mid-RUN with infl=2. Required: all outputs return to reset values asynchronously. A subsequent start runs a full frame with correct ordering.

Source files
------------

// File: rtl/conv2_sched_if.sv
// Request/result channel between conv2_sched (master) and the conv2 MAC core (slave).
interface conv2_sched_if #(
  parameter int CO     = 8,
  parameter int CO_PAR = 2,
  parameter int B_BW   = 16,
  parameter int OH     = 10,
  parameter int OW     = 10
);
  localparam int NG = CO / CO_PAR;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  logic                     o_req_valid;
  logic                     i_req_ready;
  logic [RW-1:0]            o_row;
  logic [CW-1:0]            o_col;
  logic [GW-1:0]            o_grp;
  logic [CO_PAR*B_BW-1:0]   o_bias;
  logic                     o_last;
  logic                     i_res_valid;

  modport master (
    output o_req_valid, o_row, o_col, o_grp, o_bias, o_last,
    input  i_req_ready, i_res_valid
  );

  modport slave (
    input  o_req_valid, o_row, o_col, o_grp, o_bias, o_last,
    output i_req_ready, i_res_valid
  );
endinterface

// File: rtl/conv2_sched.sv
// Conv2 stage sequencer: walks (row, col, grp), issues one core request per step,
// bounds requests in flight and reports frame completion.
module conv2_sched #(
  parameter int CO       = 8,
  parameter int CO_PAR   = 2,
  parameter int B_BW     = 16,
  parameter int OH       = 10,
  parameter int OW       = 10,
  parameter int MAX_INFL = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [CO*B_BW-1:0]   i_bias,
  conv2_sched_if.master        bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);
  localparam int NG = CO / CO_PAR;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int IW = $clog2(MAX_INFL + 1);

  localparam logic [RW-1:0] ROW_L    = RW'(OH - 1);
  localparam logic [CW-1:0] COL_L    = CW'(OW - 1);
  localparam logic [GW-1:0] GRP_L    = GW'(NG - 1);
  localparam logic [IW-1:0] INFL_MAX = IW'(MAX_INFL);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [GW-1:0] grp;
  logic [IW-1:0] infl;
  logic          acc, last, start;

  logic [NG-1:0][CO_PAR*B_BW-1:0] bias_g;

  assign bias_g = i_bias;
  assign last   = (row == ROW_L) && (col == COL_L) && (grp == GRP_L);
  assign start  = (state == IDLE) && i_start;

  // Valid depends only on registered state, never on ready.
  assign bus.o_req_valid = (state == RUN) && (infl < INFL_MAX);
  assign acc             = bus.o_req_valid && bus.i_req_ready;
  assign bus.o_row       = row;
  assign bus.o_col       = col;
  assign bus.o_grp       = grp;
  assign bus.o_last      = last;
  assign bus.o_bias      = bias_g[grp];
  assign o_busy          = (state == RUN) || (state == DRAIN);
  assign o_done          = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = RUN;
      RUN:     if (acc && last) state_nx = DRAIN;
      DRAIN:   if (infl == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      grp   <= '0;
      infl  <= '0;
      o_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        row   <= '0;
        col   <= '0;
        grp   <= '0;
        infl  <= '0;
        o_err <= 1'b0;
      end else begin
        // grp fastest, then col, then row; all wrap to 0 after the last request.
        if (acc) begin
          if (grp == GRP_L) begin
            grp <= '0;
            if (col == COL_L) begin
              col <= '0;
              row <= (row == ROW_L) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end else begin
            grp <= grp + 1'b1;
          end
        end
        if (acc && !bus.i_res_valid) begin
          infl <= infl + 1'b1;
        end else if (!acc && bus.i_res_valid) begin
          if (infl == '0) o_err <= 1'b1;
          else            infl  <= infl - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv2_sched.sv
// Randomized self-checking bench for conv2_sched against a counting reference model.
module tb_conv2_sched;
  localparam int CO = 8, CO_PAR = 2, B_BW = 16, OH = 2, OW = 2, MAX_INFL = 4;
  localparam int NG = CO / CO_PAR;
  localparam int TOTAL = OH * OW * NG;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int PW = RW + CW + GW + 1 + CO_PAR * B_BW;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 i_start = 1'b0;
  logic [CO*B_BW-1:0]   i_bias = '0;
  logic                 o_busy, o_done, o_err;

  // model state: requests issued (n), results outstanding (pend), expected error flag
  int n_cmp = 0, n_bad = 0, pend = 0, n = 0, cyc = 0;
  bit merr = 1'b0;

  conv2_sched_if #(.CO(CO), .CO_PAR(CO_PAR), .B_BW(B_BW), .OH(OH), .OW(OW)) bus ();

  conv2_sched #(.CO(CO), .CO_PAR(CO_PAR), .B_BW(B_BW), .OH(OH), .OW(OW), .MAX_INFL(MAX_INFL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (i_start),
    .i_bias  (i_bias),
    .bus     (bus.master),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  // Expected payload of the idx-th request of a frame: raster order, groups fastest.
  function automatic logic [PW-1:0] exp_pl(input int idx);
    int g, c, r;
    logic [CO_PAR*B_BW-1:0] b;
    g = idx % NG;
    c = (idx / NG) % OW;
    r = idx / (OW * NG);
    for (int k = 0; k < CO_PAR; k++)
      b[k*B_BW +: B_BW] = i_bias[(g*CO_PAR + k)*B_BW +: B_BW];
    return {RW'(r), CW'(c), GW'(g), (idx == TOTAL - 1), b};
  endfunction

  function automatic logic [PW-1:0] got_pl();
    return {bus.o_row, bus.o_col, bus.o_grp, bus.o_last, bus.o_bias};
  endfunction

  function automatic void model_upd(input bit acc, input bit rv);
    if (acc) n++;
    if (acc && !rv) pend++;
    else if (!acc && rv) begin
      if (pend == 0) merr = 1'b1;
      else pend--;
    end
  endfunction

  task automatic step(input bit r, input bit rv, input bit st, output bit acc);
    @(negedge clk);
    bus.i_req_ready = r;
    bus.i_res_valid = rv;
    i_start = st;
    #1;
    acc = (bus.o_req_valid === 1'b1) && r;
    cyc++;
  endtask

  task automatic do_start();
    bit a;
    step(1'b0, 1'b0, 1'b1, a);
    pend = 0;
    n = 0;
    merr = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    bit acc, rv, seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      rv = (pend > 0);
      step(1'b1, rv, 1'b0, acc);
      n_cmp++;
      if (bus.o_req_valid !== 1'((n < TOTAL) && (pend < MAX_INFL))) begin
        n_bad++;
        $display("FAIL %s_valid n=%0d pend=%0d got=%b", tag, n, pend, bus.o_req_valid);
      end
      if (bus.o_req_valid === 1'b1 && n < TOTAL) begin
        n_cmp++;
        if (got_pl() !== exp_pl(n)) begin
          n_bad++;
          $display("FAIL %s_payload idx=%0d got=%h exp=%h", tag, n, got_pl(), exp_pl(n));
        end
      end
      if (o_done === 1'b1) seen = 1'b1;
      model_upd(acc, rv);
    end
    n_cmp++;
    if (!seen || n != TOTAL) begin
      n_bad++;
      $display("FAIL %s_finish done_seen=%0d requests=%0d exp=%0d", tag, seen, n, TOTAL);
    end
  endtask

  task automatic test_reset();
    bit a;
    bus.i_req_ready = 1'b0;
    bus.i_res_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.o_req_valid, bus.o_row, bus.o_col, bus.o_grp, bus.o_last, o_busy, o_done, o_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_vals got=%b exp=0",
               {bus.o_req_valid, bus.o_row, bus.o_col, bus.o_grp, bus.o_last, o_busy, o_done, o_err});
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, a);
    n_cmp++;
    if ({bus.o_req_valid, o_busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset got=%b exp=00", {bus.o_req_valid, o_busy});
    end
  endtask

  task automatic test_frame_inorder();
    bit acc, prev;
    int first_acc, last_acc, last_res, done_cyc;
    first_acc = -1; last_acc = -1; last_res = -1; done_cyc = -1;
    for (int c = 0; c < CO; c++) i_bias[c*B_BW +: B_BW] = B_BW'($urandom);
    do_start();
    prev = 1'b0;
    for (int k = 0; k < 100 && done_cyc < 0; k++) begin
      step(1'b1, prev, 1'b0, acc);
      if (k == 0) begin
        n_cmp++;
        if ({o_busy, bus.o_req_valid} !== 2'b11) begin
          n_bad++;
          $display("FAIL start_latency busy_valid got=%b exp=11", {o_busy, bus.o_req_valid});
        end
      end
      n_cmp++;
      if (bus.o_req_valid !== 1'((n < TOTAL) && (pend < MAX_INFL))) begin
        n_bad++;
        $display("FAIL inorder_valid n=%0d got=%b", n, bus.o_req_valid);
      end
      if (bus.o_req_valid === 1'b1 && n < TOTAL) begin
        n_cmp++;
        if (got_pl() !== exp_pl(n)) begin
          n_bad++;
          $display("FAIL inorder_payload idx=%0d got=%h exp=%h", n, got_pl(), exp_pl(n));
        end
      end
      if (o_done === 1'b1) begin
        done_cyc = cyc;
        n_cmp++;
        if (o_busy !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_in_done got=%b exp=0", o_busy);
        end
      end
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (prev) last_res = cyc;
      model_upd(acc, prev);
      prev = acc;
    end
    n_cmp++;
    if (done_cyc < 0 || n != TOTAL) begin
      n_bad++;
      $display("FAIL inorder_count requests=%0d exp=%0d done_cyc=%0d", n, TOTAL, done_cyc);
    end
    n_cmp++;
    if (last_acc - first_acc != TOTAL - 1) begin
      n_bad++;
      $display("FAIL inorder_throughput span=%0d exp=%0d", last_acc - first_acc, TOTAL - 1);
    end
    n_cmp++;
    if (done_cyc - last_res != 2) begin
      n_bad++;
      $display("FAIL done_latency got=%0d exp=2", done_cyc - last_res);
    end
  endtask

  task automatic test_bias_hold();
    bit acc;
    logic [CO_PAR*B_BW-1:0] want;
    want = 32'h0105_0104;
    for (int c = 0; c < CO; c++) i_bias[c*B_BW +: B_BW] = B_BW'(16'h0100 + c);
    do_start();
    repeat (2) begin
      step(1'b1, 1'b0, 1'b0, acc);
      model_upd(acc, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, acc);
      n_cmp++;
      if (bus.o_req_valid !== 1'b1 || bus.o_bias !== want || got_pl() !== exp_pl(2)) begin
        n_bad++;
        $display("FAIL bias_hold cyc=%0d valid=%b got=%h exp=%h", k, bus.o_req_valid, got_pl(), exp_pl(2));
      end
      model_upd(acc, 1'b0);
    end
    finish_frame("bias");
  endtask

  task automatic test_infl_limit();
    bit acc;
    int cnt;
    i_bias = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_start();
    cnt = 0;
    repeat (8) begin
      step(1'b1, 1'b0, 1'b0, acc);
      if (acc) cnt++;
      model_upd(acc, 1'b0);
    end
    n_cmp++;
    if (cnt != MAX_INFL) begin
      n_bad++;
      $display("FAIL infl_cap accepted=%0d exp=%0d", cnt, MAX_INFL);
    end
    step(1'b1, 1'b1, 1'b0, acc);
    n_cmp++;
    if (bus.o_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL infl_full_valid got=%b exp=0", bus.o_req_valid);
    end
    model_upd(acc, 1'b1);
    cnt = 0;
    repeat (4) begin
      step(1'b1, 1'b0, 1'b0, acc);
      if (acc) cnt++;
      model_upd(acc, 1'b0);
    end
    n_cmp++;
    if (cnt != 1) begin
      n_bad++;
      $display("FAIL infl_one_more accepted=%0d exp=1", cnt);
    end
    // bring infl to 3, then a result coincident with an acceptance
    step(1'b1, 1'b1, 1'b0, acc);
    model_upd(acc, 1'b1);
    step(1'b1, 1'b1, 1'b0, acc);
    n_cmp++;
    if (acc !== 1'b1) begin
      n_bad++;
      $display("FAIL coincident_accept got=%b exp=1", acc);
    end
    model_upd(acc, 1'b1);
    step(1'b0, 1'b0, 1'b0, acc);
    n_cmp++;
    if (bus.o_req_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL coincident_valid got=%b exp=1", bus.o_req_valid);
    end
    step(1'b1, 1'b0, 1'b0, acc);
    model_upd(acc, 1'b0);
    step(1'b0, 1'b0, 1'b0, acc);
    n_cmp++;
    if (bus.o_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL coincident_infl3 valid got=%b exp=0 (infl should be full)", bus.o_req_valid);
    end
    finish_frame("infl");
  endtask

  task automatic test_err_idle();
    bit acc, rv;
    step(1'b0, 1'b1, 1'b0, acc);
    model_upd(acc, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, acc);
      n_cmp++;
      if (o_err !== merr) begin
        n_bad++;
        $display("FAIL err_sticky cyc=%0d got=%b exp=%b", k, o_err, merr);
      end
    end
    do_start();
    for (int k = 0; k < 5; k++) begin
      rv = (pend > 0);
      step(1'b1, rv, (k == 2), acc);
      if (k == 0) begin
        n_cmp++;
        if (o_err !== 1'b0) begin
          n_bad++;
          $display("FAIL err_clear_on_start got=%b exp=0", o_err);
        end
      end
      if (bus.o_req_valid === 1'b1 && n < TOTAL) begin
        n_cmp++;
        if (got_pl() !== exp_pl(n)) begin
          n_bad++;
          $display("FAIL restart_payload idx=%0d got=%h exp=%h", n, got_pl(), exp_pl(n));
        end
      end
      model_upd(acc, rv);
    end
    finish_frame("restart");
  endtask

  task automatic test_random_frame(input string tag);
    bit acc, rv, r;
    int last_res, done_cyc;
    last_res = -1; done_cyc = -1;
    i_bias = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_start();
    for (int k = 0; k < 400 && done_cyc < 0; k++) begin
      r  = ($urandom_range(0, 3) != 0);
      rv = (pend > 0) && ($urandom_range(0, 1) == 1);
      step(r, rv, 1'b0, acc);
      if (k == 0) begin
        n_cmp++;
        if ({o_busy, o_err} !== 2'b10) begin
          n_bad++;
          $display("FAIL %s_first busy_err got=%b exp=10", tag, {o_busy, o_err});
        end
      end
      n_cmp++;
      if (bus.o_req_valid !== 1'((n < TOTAL) && (pend < MAX_INFL))) begin
        n_bad++;
        $display("FAIL %s_valid n=%0d pend=%0d got=%b", tag, n, pend, bus.o_req_valid);
      end
      if (bus.o_req_valid === 1'b1 && n < TOTAL) begin
        n_cmp++;
        if (got_pl() !== exp_pl(n)) begin
          n_bad++;
          $display("FAIL %s_payload idx=%0d got=%h exp=%h", tag, n, got_pl(), exp_pl(n));
        end
      end
      if (o_done === 1'b1) begin
        done_cyc = cyc;
        n_cmp++;
        if (o_busy !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_busy_in_done got=%b exp=0", tag, o_busy);
        end
      end
      if (rv) last_res = cyc;
      model_upd(acc, rv);
    end
    n_cmp++;
    if (done_cyc < 0 || n != TOTAL || done_cyc - last_res != 2) begin
      n_bad++;
      $display("FAIL %s_end requests=%0d exp=%0d done_gap=%0d exp=2", tag, n, TOTAL, done_cyc - last_res);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    i_bias = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_start();
    repeat (2) begin
      step(1'b1, 1'b0, 1'b0, acc);
      model_upd(acc, 1'b0);
    end
    bus.i_req_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_req_valid, bus.o_row, bus.o_col, bus.o_grp, bus.o_last, o_busy, o_done, o_err} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got=%b exp=0",
               {bus.o_req_valid, bus.o_row, bus.o_col, bus.o_grp, bus.o_last, o_busy, o_done, o_err});
    end
    @(negedge clk);
    reset_n = 1'b1;
    pend = 0; n = 0; merr = 1'b0;
    step(1'b0, 1'b1, 1'b0, acc);
    model_upd(acc, 1'b1);
    step(1'b0, 1'b0, 1'b0, acc);
    n_cmp++;
    if (o_err !== merr || o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL late_result err_done got=%b%b exp=%b0", o_err, o_done, merr);
    end
    test_random_frame("post_reset");
  endtask

  initial begin
    test_reset();
    test_frame_inorder();
    test_bias_hold();
    test_infl_limit();
    test_err_idle();
    test_reset_mid();
    test_random_frame("back_to_back");
    test_random_frame("random");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
